// File: rtl/branch_ctrl.sv
// Purpose: ID-stage branch resolution, PC sequencing, IF/ID flush and comparator-operand hazard stall.
// Latency: Taken/Flush/Stall are combinational this cycle; PC redirect, state and TakenCount update at the next Clk edge.
// Backpressure: Stall holds PC and IF/ID (bubble into ID/EX); one extra HOLD cycle covers a load in EX.
//
// Ports:
//   Clk, Reset_n                  clock, asynchronous active-low reset
//   BranchOp                      ID instruction class (000 none .. 111 j/jal)
//   Zero, Sign                    ID comparator flags for (A - B)
//   BranchTarget, JumpTarget      candidate redirect addresses
//   RsID/RtID, UsesRs/UsesRt      comparator sources and whether each is read
//   WriteReg_EX, RegWrite_EX, MemRead_EX   EX-stage producer
//   WriteReg_MEM, MemRead_MEM     MEM-stage producer (only loads matter here)
//   PC                            registered fetch address
//   Stall, Flush, Taken           front-end control for this cycle
//   TakenCount                    wrapping count of redirects since reset
module branch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [2:0]  BranchOp,
    input  logic        Zero,
    input  logic        Sign,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [4:0]  RsID,
    input  logic [4:0]  RtID,
    input  logic        UsesRs,
    input  logic        UsesRt,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemRead_EX,
    input  logic [4:0]  WriteReg_MEM,
    input  logic        MemRead_MEM,
    output logic [31:0] PC,
    output logic        Stall,
    output logic        Flush,
    output logic        Taken,
    output logic [15:0] TakenCount
);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;
    localparam logic [2:0] OP_BLTZ = 3'b101;
    localparam logic [2:0] OP_BGEZ = 3'b110;
    localparam logic [2:0] OP_JUMP = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic        haz_ex;
    logic        haz_mem;
    logic        is_cond;
    logic        cond_true;
    logic        stall_int;
    logic        taken_int;

    // $0 is hardwired to zero, so a "write" to it never creates a dependency.
    function automatic logic src_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] dst);
        return used && (src != 5'd0) && (src == dst);
    endfunction

    // Hazard detection and next-state.
    always_comb begin
        haz_ex    = RegWrite_EX &&
                    (src_match(UsesRs, RsID, WriteReg_EX) || src_match(UsesRt, RtID, WriteReg_EX));
        haz_mem   = MemRead_MEM &&
                    (src_match(UsesRs, RsID, WriteReg_MEM) || src_match(UsesRt, RtID, WriteReg_MEM));
        is_cond   = (BranchOp != OP_NONE) && (BranchOp != OP_JUMP);
        stall_int = 1'b0;
        state_nxt = RUN;
        case (state)
            RUN: begin
                stall_int = is_cond && (haz_ex || haz_mem);
                // A load in EX still needs its MEM cycle before data can be forwarded
                // to ID, so spend one more cycle in HOLD regardless of what arrives.
                if (stall_int && MemRead_EX && haz_ex) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                stall_int = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                stall_int = 1'b0;
                state_nxt = RUN;
            end
        endcase
    end

    // Branch condition decode and redirect.
    always_comb begin
        cond_true = 1'b0;
        case (BranchOp)
            OP_NONE: cond_true = 1'b0;
            OP_BEQ:  cond_true = Zero;
            OP_BNE:  cond_true = !Zero;
            OP_BLEZ: cond_true = Sign || Zero;
            OP_BGTZ: cond_true = !Sign && !Zero;
            OP_BLTZ: cond_true = Sign;
            OP_BGEZ: cond_true = !Sign;
            OP_JUMP: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase

        // A stalled branch is resolved only once its operands are valid.
        taken_int = !stall_int && cond_true;

        pc_nxt = PC + 32'd4;
        if (stall_int) begin
            pc_nxt = PC;
        end else if (taken_int && (BranchOp == OP_JUMP)) begin
            pc_nxt = JumpTarget & ~32'd3;
        end else if (taken_int) begin
            pc_nxt = BranchTarget & ~32'd3;
        end
    end

    assign Stall = stall_int;
    assign Taken = taken_int;
    assign Flush = taken_int;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= RUN;
            PC         <= PC_RESET;
            TakenCount <= 16'd0;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
            if (taken_int) begin
                TakenCount <= TakenCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_branch_ctrl;

    localparam logic [31:0] PC_RST = 32'h0040_0000;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [2:0]  BranchOp;
    logic        Zero, Sign;
    logic [31:0] BranchTarget, JumpTarget;
    logic [4:0]  RsID, RtID;
    logic        UsesRs, UsesRt;
    logic [4:0]  WriteReg_EX;
    logic        RegWrite_EX, MemRead_EX;
    logic [4:0]  WriteReg_MEM;
    logic        MemRead_MEM;
    logic [31:0] PC;
    logic        Stall, Flush, Taken;
    logic [15:0] TakenCount;

    branch_ctrl #(.PC_RESET(PC_RST)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .BranchOp(BranchOp), .Zero(Zero), .Sign(Sign),
        .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .RsID(RsID), .RtID(RtID),
        .UsesRs(UsesRs), .UsesRt(UsesRt), .WriteReg_EX(WriteReg_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .WriteReg_MEM(WriteReg_MEM),
        .MemRead_MEM(MemRead_MEM), .PC(PC), .Stall(Stall), .Flush(Flush), .Taken(Taken),
        .TakenCount(TakenCount)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: PC, redirect count and number of forced stall cycles still owed.
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    int          m_owed;
    logic        e_stall, e_taken;
    logic [31:0] e_pc;
    int          e_owed;

    function automatic logic reads(input logic u, input logic [4:0] s, input logic [4:0] d);
        return u && (s != 0) && (s == d);
    endfunction

    task automatic model_eval();
        logic dep_ex, dep_mem, want;
        dep_ex  = RegWrite_EX && (reads(UsesRs, RsID, WriteReg_EX) || reads(UsesRt, RtID, WriteReg_EX));
        dep_mem = MemRead_MEM && (reads(UsesRs, RsID, WriteReg_MEM) || reads(UsesRt, RtID, WriteReg_MEM));
        if (m_owed > 0) e_stall = 1'b1;
        else e_stall = (BranchOp inside {[3'd1:3'd6]}) && (dep_ex || dep_mem);
        e_owed = (m_owed == 0 && e_stall && MemRead_EX && dep_ex) ? 1 : 0;
        case (BranchOp)
            3'd1:    want = Zero;
            3'd2:    want = !Zero;
            3'd3:    want = Sign || Zero;
            3'd4:    want = !Sign && !Zero;
            3'd5:    want = Sign;
            3'd6:    want = !Sign;
            3'd7:    want = 1'b1;
            default: want = 1'b0;
        endcase
        e_taken = want && !e_stall;
        if (e_stall)                      e_pc = m_pc;
        else if (e_taken && BranchOp == 7) e_pc = {JumpTarget[31:2], 2'b00};
        else if (e_taken)                 e_pc = {BranchTarget[31:2], 2'b00};
        else                              e_pc = m_pc + 32'd4;
    endtask

    task automatic model_reset();
        m_pc   = PC_RST;
        m_cnt  = 16'd0;
        m_owed = 0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic advance(input bit do_chk);
        #1;
        model_eval();
        if (do_chk) begin
            chk("stall", {31'd0, Stall}, {31'd0, e_stall});
            chk("taken", {31'd0, Taken}, {31'd0, e_taken});
            chk("flush", {31'd0, Flush}, {31'd0, e_taken});
            chk("pc", PC, m_pc);
            chk("count", {16'd0, TakenCount}, {16'd0, m_cnt});
        end
        @(posedge Clk);
        m_pc   = e_pc;
        m_owed = e_owed;
        if (e_taken) m_cnt = m_cnt + 16'd1;
        @(negedge Clk);
    endtask

    task automatic clr();
        BranchOp = 3'd0; Zero = 1'b0; Sign = 1'b0;
        BranchTarget = 32'h0040_0100; JumpTarget = 32'h0040_0200;
        RsID = 5'd0; RtID = 5'd0; UsesRs = 1'b0; UsesRt = 1'b0;
        WriteReg_EX = 5'd0; RegWrite_EX = 1'b0; MemRead_EX = 1'b0;
        WriteReg_MEM = 5'd0; MemRead_MEM = 1'b0;
    endtask

    task automatic reset_pulse();
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pc", PC, PC_RST);
        chk("rst_cnt", {16'd0, TakenCount}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    logic [31:0] pc0;

    initial begin
        clr();
        Reset_n = 1'b0;
        model_reset();
        #12;
        chk("reset_pc", PC, 32'h0040_0000);
        chk("reset_count", {16'd0, TakenCount}, 32'd0);
        chk("reset_stall", {31'd0, Stall}, 32'd0);
        chk("reset_flush", {31'd0, Flush}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) advance(1);
        chk("pc_after_3", PC, 32'h0040_000C);

        // Decode sweep over all six conditional branches and flag combinations.
        for (int op = 1; op <= 6; op++) begin
            for (int zs = 0; zs < 4; zs++) begin
                clr();
                BranchOp = 3'(op);
                Zero = zs[1];
                Sign = zs[0];
                advance(1);
                if (e_taken) chk("br_target", PC, 32'h0040_0100);
                clr();
                advance(1);
            end
        end

        // ALU producer in EX: one stall cycle, then resolve.
        clr();
        BranchOp = 3'd1; RsID = 5'd8; UsesRs = 1'b1; WriteReg_EX = 5'd8; RegWrite_EX = 1'b1;
        pc0 = PC;
        #1 chk("alu_stall", {31'd0, Stall}, 32'd1);
        advance(1);
        chk("alu_pc_held", PC, pc0);
        RegWrite_EX = 1'b0; Zero = 1'b1;
        #1 chk("alu_taken", {31'd0, Taken}, 32'd1);
        advance(1);
        chk("alu_target", PC, 32'h0040_0100);

        // Load in EX: two stall cycles, the second regardless of MEM inputs.
        clr();
        BranchOp = 3'd2; RtID = 5'd9; UsesRt = 1'b1;
        WriteReg_EX = 5'd9; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
        #1 chk("ld_stall1", {31'd0, Stall}, 32'd1);
        advance(1);
        RegWrite_EX = 1'b0; MemRead_EX = 1'b0; WriteReg_EX = 5'd0;
        WriteReg_MEM = 5'd5; MemRead_MEM = 1'b1;
        #1 chk("ld_stall2", {31'd0, Stall}, 32'd1);
        advance(1);
        #1 chk("ld_resolve", {31'd0, Taken}, 32'd1);
        advance(1);

        // Load in MEM alone: one stall cycle.
        clr();
        BranchOp = 3'd6; RsID = 5'd4; UsesRs = 1'b1; WriteReg_MEM = 5'd4; MemRead_MEM = 1'b1;
        advance(1);
        MemRead_MEM = 1'b0;
        advance(1);

        // $0 never stalls; jumps ignore hazards.
        clr();
        BranchOp = 3'd1; UsesRs = 1'b1; RegWrite_EX = 1'b1;
        #1 chk("r0_nostall", {31'd0, Stall}, 32'd0);
        advance(1);
        clr();
        BranchOp = 3'd7; JumpTarget = 32'h0040_1234;
        RsID = 5'd8; UsesRs = 1'b1; WriteReg_EX = 5'd8; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
        #1 chk("j_nostall", {31'd0, Stall}, 32'd0);
        chk("j_flush", {31'd0, Flush}, 32'd1);
        advance(1);
        chk("j_pc", PC, 32'h0040_1234);

        // PC wrap.
        clr();
        BranchOp = 3'd7; JumpTarget = 32'hFFFF_FFFC;
        advance(1);
        clr();
        advance(1);
        chk("pc_wrap", PC, 32'h0000_0000);

        // Reset during HOLD.
        clr();
        BranchOp = 3'd1; RsID = 5'd8; UsesRs = 1'b1;
        WriteReg_EX = 5'd8; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
        advance(1);
        clr();
        #1 chk("hold_uncond", {31'd0, Stall}, 32'd1);
        reset_pulse();
        chk("post_rst_stall", {31'd0, Stall}, 32'd0);
        advance(1);

        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            BranchOp     = 3'($urandom_range(0, 7));
            Zero         = 1'($urandom_range(0, 1));
            Sign         = 1'($urandom_range(0, 1));
            BranchTarget = $urandom;
            JumpTarget   = $urandom;
            RsID         = 5'($urandom_range(0, 3));
            RtID         = 5'($urandom_range(0, 3));
            UsesRs       = 1'($urandom_range(0, 1));
            UsesRt       = 1'($urandom_range(0, 1));
            WriteReg_EX  = 5'($urandom_range(0, 3));
            RegWrite_EX  = 1'($urandom_range(0, 1));
            MemRead_EX   = 1'($urandom_range(0, 1));
            WriteReg_MEM = 5'($urandom_range(0, 3));
            MemRead_MEM  = 1'($urandom_range(0, 1));
            advance(1);
        end

        // 65536 redirects wrap the counter back to zero.
        clr();
        reset_pulse();
        BranchOp = 3'd7;
        JumpTarget = 32'h0040_0040;
        repeat (65536) advance(0);
        chk("count_wrap", {16'd0, TakenCount}, 32'd0);
        clr();
        advance(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and PC sequencing for the ID-stage branch path of the pipelined MIPS datapath. Consumes the Zero/Sign flags produced by the ID-stage equality/sign comparator. Decides taken/not-taken for conditional branches and jumps, owns the PC register, and drives IF/ID flush. Detects operand hazards on the comparator inputs and stalls the front end until forwarded values are valid.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- BranchOp  in  3  ID instruction class: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 j/jal
- Zero  in  1  comparator: (A − B) == 0; for single-register branches B = 0
- Sign  in  1  comparator: bit 31 of (A − B)
- BranchTarget  in  32  PC+4 of branch + (sign-extended imm << 2), computed in ID
- JumpTarget  in  32  {PC+4[31:28], imm26, 2'b00}
- RsID, RtID  in  5 each  comparator source registers
- UsesRs, UsesRt  in  1 each  comparator actually reads Rs / Rt
- WriteReg_EX  in  5  destination register of the EX instruction
- RegWrite_EX, MemRead_EX  in  1 each  EX instruction writes a register / is a load
- WriteReg_MEM  in  5  destination register of the MEM instruction
- MemRead_MEM  in  1  MEM instruction is a load
- PC  out  32  registered fetch address
- Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- Flush  out  1  zero IF/ID at next edge
- Taken  out  1  redirect this cycle
- TakenCount  out  16  count of redirects since reset

## Operation
- Hazard match (per source): Used && Reg != 0 && Reg == WriteReg_x.
- FSM states RUN, HOLD. Reset → RUN.
- RUN:
  - HazEX = RegWrite_EX && match(EX).
  - HazMEM = MemRead_MEM && match(MEM).
  - Stall = BranchOp != 000 && BranchOp != 111 && (HazEX || HazMEM). Jumps never stall.
  - If Stall && MemRead_EX && HazEX → next HOLD, otherwise stay in RUN.
- HOLD: Stall = 1 unconditionally; all EX/MEM hazard inputs ignored; next state RUN.
- Taken is evaluated only when Stall = 0, otherwise it is 0:
  - beq: Zero
  - bne: !Zero
  - blez: Sign || Zero
  - bgtz: !Sign && !Zero
  - bltz: Sign
  - bgez: !Sign
  - j: 1
  - none: 0
- Flush = Taken.
- Next PC:
  - Stall → PC.
  - Taken and BranchOp = 111 → JumpTarget.
  - Taken otherwise → BranchTarget.
  - Else → PC + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- Bits [1:0] of the loaded target are forced to 00.
- TakenCount increments by 1 on each edge where Taken = 1; wraps 16'hFFFF → 0.
- Stall and Flush are never both 1.

## Timing
- Reset (async, Reset_n = 0): PC = PC_RESET, state RUN, TakenCount = 0. Stall, Flush and Taken derive from state and inputs, so they are 0 while BranchOp = 000.
- Reset assertion mid-HOLD aborts the hold immediately. The first cycle after release is RUN.
- Taken, Flush and Stall are combinational from the current inputs and state. PC, state and TakenCount update on the rising Clk.
- Branch resolution latency: one cycle. The decision in cycle n puts the target on PC after edge n; exactly one delay-slot instruction is flushed.
- Stall length:
  - ALU producer in EX: 1 cycle.
  - Load in EX: 2 cycles (RUN stall + HOLD).
  - Load in MEM: 1 cycle.
  - Producer in WB: 0 cycles (register-file write-before-read).
- Upstream holds BranchOp, targets and register IDs stable while Stall = 1.

## Test plan
- Reset: Reset_n = 0 with PC_RESET = 32'h0040_0000 → PC = 0x00400000, TakenCount = 0. Release; BranchOp = 000 for 3 cycles → PC = 0x0040000C, Stall = Flush = 0.
- Branch decode sweep: for each of beq/bne/blez/bgtz/bltz/bgez, drive all four (Zero, Sign) combos with BranchTarget = 0x00400100 and no hazard → Taken matches the decode above. When taken, PC = 0x00400100 next cycle and Flush = 1 for one cycle.
- ALU hazard: beq with RsID = 8, UsesRs = 1, WriteReg_EX = 8, RegWrite_EX = 1, MemRead_EX = 0 → Stall = 1 for one cycle, PC held. Next cycle, with the hazard cleared and Zero = 1 → Taken = 1.
- Load hazard: bne with RtID = 9, load to $9 in EX → Stall = 1 for exactly two cycles, the second in HOLD even if the MEM inputs show no match. Then the branch resolves.
- $0 and jump: WriteReg_EX = 0 matching RsID = 0 → no stall. j with JumpTarget = 0x00401234 while an EX hazard is present → no stall; PC = 0x00401234, Flush = 1.
- Wrap and mid-hold reset:
  - PC = 0xFFFFFFFC, no branch → PC = 0.
  - 65536 taken branches → TakenCount = 0.
  - Reset_n pulse during HOLD → state RUN, Stall = 0 after release.
